alu_station: RTL and testbench
==============================

// Module: alu_station
// PURPOSE
//  Reservation station between dispatch and one ALU. Accepts one dispatched op per cycle with operands
//  read from reg_stat as {data, tag}, snoops the three write-back buses for missing operands, and issues
//  the oldest ready entry to its ALU. Tags name the producing unit (UNLOCKED / ALU_MASTER / ALU_SALVER /
//  LOAD_STORE); wakeup therefore matches {unit bus, source register address}.
// PARAMETERS
//  DEPTH  4  entries (power of two, 2..8)
//  OP_W   6  width of decoded ALU opcode field
// PORTS
//  clk       in   1       clock; single clock domain
//  rst       in   1       synchronous, active-high reset
//  rdy       in   1       global enable; state holds when low
//  flush     in   1       mispredict: discard all entries
//  in_valid  in   1       dispatch presents an op
//  in_op     in   OP_W    decoded opcode
//  in_rd     in   5       destination register
//  in_ax/ay  in   5       source register addresses (for wakeup match)
//  in_dx/dy  in   32      operand data from reg_stat (imm when source unused)
//  in_tx/ty  in   2       operand tags from reg_stat
//  full      out  1       no free entry; dispatch must not assert in_valid
//  en_wK, addr_wK, data_wK  in 1/5/32   write-back bus K=0 (ALU_MASTER), 1 (ALU_SALVER), 2 (LOAD_STORE)
//  out_valid in/out: out  1  issue valid to ALU
//  out_ready in   1       ALU accepts this cycle
//  out_op    out  OP_W    issued opcode
//  out_x/y   out  32      issued operands
//  out_rd    out  5       issued destination
// BEHAVIOUR
//  - Reset/flush (rst, or flush with rdy): all entries invalid, age counters 0; full=0, out_valid=0.
//    flush wins over same-cycle insert and issue. rst acts regardless of rdy.
//  - rdy low: no state change; outputs stay combinationally consistent with held state.
//  - Entry = {valid, op, rd, ax, dx, tx, ay, dy, ty, age}. Operand ready iff tag==UNLOCKED.
//  - Insert: in_valid & ~full & rdy writes the lowest-index free entry; age = 0, all other valid ages +1
//    (saturate at DEPTH-1). in_valid while full is a protocol error: ignored, no state change.
//  - Same-cycle bypass at insert: if in_tx==unit K, en_wK, addr_wK==in_ax and addr_wK!=0, store data_wK
//    with tag UNLOCKED (reg_stat has not yet updated). Same for y. Tag UNLOCKED passes through as-is.
//  - Wakeup: each cycle, every valid entry operand with tag==K, en_wK, addr_wK==addr captures data_wK
//    and becomes UNLOCKED. Unit-to-bus mapping fixed: ALU_MASTER->0, ALU_SALVER->1, LOAD_STORE->2.
//    addr 0 never wakes anything (x0 never locked).
//  - Select: combinational; candidate = valid & both tags UNLOCKED (registered state only; wakeup in
//    cycle N makes entry issuable in N+1). Pick largest age; ties -> lowest index. out_valid=any cand.
//  - Issue: out_valid & out_ready & rdy clears the selected entry. Insert into the entry freed the same
//    cycle is NOT allowed (full is from registered state); insert goes to another free slot.
//  - full = all DEPTH entries valid (registered state); latency dispatch->issue min 1 cycle.
//  - Simultaneous: insert+issue+wakeup in one cycle all apply; ages of surviving entries +1 on insert.
// STRUCTURE
//  - Shared package/header: word_t(32), regaddr_t(5), regtag_t(2), UNLOCKED/ALU_MASTER/ALU_SALVER/
//    LOAD_STORE encodings, OP_W default; tag->bus mapping function.
//  - Sub-module rs_operand: one operand slot (load/bypass/wakeup logic), instantiated 2*DEPTH times.
//  - Top: free-slot priority encoder, age-based select, age update.
// TESTING
//  1 Insert op, tx=ty=UNLOCKED, dx=5, dy=7, out_ready=1 -> next cycle out_valid=1, out_x=5, out_y=7; entry freed.
//  2 Insert tx=ALU_MASTER ax=3; 2 cycles later en_w0 addr 3 data 0x11 -> out_valid next cycle with out_x=0x11;
//    en_w1 on addr 3 instead must NOT wake it.
//  3 Insert with tx=LOAD_STORE ax=9 while en_w2 addr 9 data 0xAB same cycle -> issues next cycle, out_x=0xAB.
//  4 Fill 4 entries, out_ready=0 -> full=1; extra in_valid ignored; release out_ready -> issue order = insert order.
//  5 Two ready entries, older blocked then woken -> older issues first once ready; younger waits.
//  6 Entries pending, flush=1 with in_valid=1 -> all invalid, full=0, out_valid=0 next cycle; rdy=0 freezes state.

Source files
------------

// File: rtl/alu_station_pkg.sv
// alu_station_pkg: shared word/register/tag types and the producer-unit tag to write-back bus mapping.
package alu_station_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regaddr_t;
    typedef logic [1:0]  regtag_t;

    localparam regtag_t UNLOCKED   = 2'd0;
    localparam regtag_t ALU_MASTER = 2'd1;
    localparam regtag_t ALU_SALVER = 2'd2;
    localparam regtag_t LOAD_STORE = 2'd3;

    localparam int OP_W_DEF = 6;

    // Only meaningful for locked tags; UNLOCKED callers must gate on the tag themselves.
    function automatic logic [1:0] tag_bus(regtag_t t);
        return t == ALU_MASTER ? 2'd0 : t == ALU_SALVER ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/alu_station_operand.sv
// rs_operand: one station operand slot; loads from dispatch with same-cycle bypass, then snoops write-back buses.
module rs_operand
    import alu_station_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic           rdy,
    input  logic           load,
    input  regaddr_t       in_addr,
    input  word_t          in_data,
    input  regtag_t        in_tag,
    input  logic [2:0]     en_w,
    input  regaddr_t [2:0] addr_w,
    input  word_t [2:0]    data_w,
    output word_t          data,
    output regtag_t        tag
);
    regaddr_t   addr_q;
    word_t      data_q;
    regtag_t    tag_q;
    regaddr_t   a;
    word_t      d;
    regtag_t    t;
    logic [1:0] b;
    logic       hit;

    // Bypass at load and wakeup afterwards share one match, applied to whichever source is live.
    always_comb begin
        a   = load ? in_addr : addr_q;
        d   = load ? in_data : data_q;
        t   = load ? in_tag  : tag_q;
        b   = tag_bus(t);
        hit = t != UNLOCKED && en_w[b] && addr_w[b] == a && a != '0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            addr_q <= '0;
            data_q <= '0;
            tag_q  <= UNLOCKED;
        end else if (rdy) begin
            addr_q <= a;
            data_q <= hit ? data_w[b] : d;
            tag_q  <= hit ? UNLOCKED : t;
        end
    end

    assign data = data_q;
    assign tag  = tag_q;

endmodule

// File: rtl/alu_station.sv
// alu_station: reservation station in front of one ALU; age-ordered issue of operand-ready entries.
module alu_station
    import alu_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [OP_W-1:0] in_op,
    input  regaddr_t        in_rd,
    input  regaddr_t        in_ax,
    input  regaddr_t        in_ay,
    input  word_t           in_dx,
    input  word_t           in_dy,
    input  regtag_t         in_tx,
    input  regtag_t         in_ty,
    output logic            full,
    input  logic            en_w0,
    input  regaddr_t        addr_w0,
    input  word_t           data_w0,
    input  logic            en_w1,
    input  regaddr_t        addr_w1,
    input  word_t           data_w1,
    input  logic            en_w2,
    input  regaddr_t        addr_w2,
    input  word_t           data_w2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output word_t           out_x,
    output word_t           out_y,
    output regaddr_t        out_rd
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(DEPTH - 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] cand;
    logic [OP_W-1:0]  op_q  [DEPTH];
    regaddr_t         rd_q  [DEPTH];
    logic [AW-1:0]    age_q [DEPTH];
    word_t            dx    [DEPTH];
    word_t            dy    [DEPTH];
    regtag_t          tx    [DEPTH];
    regtag_t          ty    [DEPTH];
    logic [AW-1:0]    free_idx;
    logic [AW-1:0]    sel_idx;
    logic [AW-1:0]    sel_age;
    logic             clr;
    logic             ins;
    logic             iss;
    logic [2:0]       en_w;
    regaddr_t [2:0]   addr_w;
    word_t [2:0]      data_w;

    assign en_w   = {en_w2, en_w1, en_w0};
    assign addr_w = {addr_w2, addr_w1, addr_w0};
    assign data_w = {data_w2, data_w1, data_w0};

    assign full = &valid_q;
    assign clr  = rst | (flush & rdy);
    assign ins  = rdy & ~flush & in_valid & ~full;
    assign iss  = rdy & ~flush & out_valid & out_ready;

    // Lowest free slot; oldest candidate with strict > so equal ages keep the lowest index.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_age   = '0;
        cand      = '0;
        out_valid = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) free_idx = valid_q[i] ? free_idx : AW'(i);
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = valid_q[i] && tx[i] == UNLOCKED && ty[i] == UNLOCKED;
            if (cand[i] && (!out_valid || age_q[i] > sel_age)) begin
                sel_idx   = AW'(i);
                sel_age   = age_q[i];
                out_valid = 1'b1;
            end
        end
    end

    assign out_op = op_q[sel_idx];
    assign out_rd = rd_q[sel_idx];
    assign out_x  = dx[sel_idx];
    assign out_y  = dy[sel_idx];

    // free_idx is never valid and sel_idx always is, so insert and issue never target one slot.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ins && free_idx == AW'(i)) begin
                    valid_q[i] <= 1'b1;
                    age_q[i]   <= '0;
                    op_q[i]    <= in_op;
                    rd_q[i]    <= in_rd;
                end else if (iss && sel_idx == AW'(i)) begin
                    valid_q[i] <= 1'b0;
                    age_q[i]   <= '0;
                end else if (ins && valid_q[i] && age_q[i] != AGE_MAX) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_operand u_x (
            .clk    (clk),
            .clr    (clr),
            .rdy    (rdy),
            .load   (ins && free_idx == AW'(g)),
            .in_addr(in_ax),
            .in_data(in_dx),
            .in_tag (in_tx),
            .en_w   (en_w),
            .addr_w (addr_w),
            .data_w (data_w),
            .data   (dx[g]),
            .tag    (tx[g])
        );
        rs_operand u_y (
            .clk    (clk),
            .clr    (clr),
            .rdy    (rdy),
            .load   (ins && free_idx == AW'(g)),
            .in_addr(in_ay),
            .in_data(in_dy),
            .in_tag (in_ty),
            .en_w   (en_w),
            .addr_w (addr_w),
            .data_w (data_w),
            .data   (dy[g]),
            .tag    (ty[g])
        );
    end

endmodule

// File: tb/tb_alu_station.sv
// tb_alu_station: directed and random stimulus against a slot/age reference model with an issue scoreboard.
module tb_alu_station;
    import alu_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, out_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_ax, in_ay;
    logic [31:0] in_dx, in_dy;
    logic [1:0]  in_tx, in_ty;
    logic        en [3];
    logic [4:0]  wa [3];
    logic [31:0] wd [3];
    logic        full, out_valid;
    logic [5:0]  out_op;
    logic [31:0] out_x, out_y;
    logic [4:0]  out_rd;

    alu_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_op(in_op), .in_rd(in_rd),
        .in_ax(in_ax), .in_ay(in_ay), .in_dx(in_dx), .in_dy(in_dy),
        .in_tx(in_tx), .in_ty(in_ty), .full(full),
        .en_w0(en[0]), .addr_w0(wa[0]), .data_w0(wd[0]),
        .en_w1(en[1]), .addr_w1(wa[1]), .data_w1(wd[1]),
        .en_w2(en[2]), .addr_w2(wa[2]), .data_w2(wd[2]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_x(out_x), .out_y(out_y), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [5:0]  op;
        logic [4:0]  rd, ax, ay;
        logic [31:0] dx, dy;
        logic [1:0]  tx, ty;
        int          age;
    } ent_t;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] x, y;
    } iss_t;

    ent_t m [4];
    iss_t exp_q [$];
    int   total = 0;
    int   bad = 0;
    bit   exp_valid = 0;
    bit   exp_full = 0;
    bit   mon_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // A locked operand is satisfied by the bus belonging to its producer unit (tag k+1 -> bus k).
    function automatic bit bus_hit(input logic [1:0] t, input logic [4:0] a, output logic [31:0] d);
        d = '0;
        for (int k = 0; k < 3; k++)
            if (t == 2'(k + 1) && en[k] && wa[k] == a && a != 0) begin
                d = wd[k];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic int pick();
        int best = -1;
        for (int i = 0; i < 4; i++)
            if (m[i].v && m[i].tx == 0 && m[i].ty == 0 && (best < 0 || m[i].age > m[best].age))
                best = i;
        return best;
    endfunction

    task automatic model_update(input int s, input bit was_full);
        logic [31:0] d;
        int f = -1;
        if (rst || (rdy && flush)) begin
            foreach (m[i]) begin
                m[i].v = 0;
                m[i].age = 0;
            end
        end else if (rdy) begin
            for (int i = 3; i >= 0; i--) if (!m[i].v) f = i;
            foreach (m[i]) if (m[i].v) begin
                if (bus_hit(m[i].tx, m[i].ax, d)) begin m[i].dx = d; m[i].tx = 0; end
                if (bus_hit(m[i].ty, m[i].ay, d)) begin m[i].dy = d; m[i].ty = 0; end
            end
            if (s >= 0 && out_ready) m[s].v = 0;
            if (in_valid && !was_full) begin
                foreach (m[i]) if (m[i].v && m[i].age < 3) m[i].age++;
                m[f] = '{v: 1, op: in_op, rd: in_rd, ax: in_ax, ay: in_ay, dx: in_dx, dy: in_dy,
                         tx: in_tx, ty: in_ty, age: 0};
                if (bus_hit(in_tx, in_ax, d)) begin m[f].dx = d; m[f].tx = 0; end
                if (bus_hit(in_ty, in_ay, d)) begin m[f].dy = d; m[f].ty = 0; end
            end
        end
    endtask

    task automatic cyc();
        int s = pick();
        int nv = 0;
        foreach (m[i]) nv += m[i].v ? 1 : 0;
        exp_valid = s >= 0;
        exp_full = nv == 4;
        if (s >= 0 && out_ready && rdy && !flush && !rst)
            exp_q.push_back('{op: m[s].op, rd: m[s].rd, x: m[s].dx, y: m[s].dy});
        @(posedge clk);
        model_update(s, nv == 4);
        #1;
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; in_valid = 0; out_ready = 1;
        in_op = 0; in_rd = 0; in_ax = 0; in_ay = 0; in_dx = 0; in_dy = 0; in_tx = 0; in_ty = 0;
        foreach (en[k]) begin en[k] = 0; wa[k] = 0; wd[k] = 0; end
    endtask

    task automatic disp(input logic [5:0] op, input logic [4:0] ax, input logic [1:0] tx,
                        input logic [31:0] dx, input logic [4:0] ay, input logic [1:0] ty,
                        input logic [31:0] dy);
        in_valid = 1; in_op = op; in_rd = op[4:0];
        in_ax = ax; in_tx = tx; in_dx = dx; in_ay = ay; in_ty = ty; in_dy = dy;
    endtask

    initial begin
        iss_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                check("full", full, exp_full);
                check("out_valid", out_valid, exp_valid);
                if (out_valid && out_ready && rdy && !flush && !rst) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL issue: got op %0h with nothing expected at %0t", out_op, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_op", out_op, e.op);
                        check("out_rd", out_rd, e.rd);
                        check("out_x", out_x, e.x);
                        check("out_y", out_y, e.y);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1;
        cyc();
        mon_on = 1;
        cyc();
        idle();
        check("reset_full", full, 0);
        check("reset_valid", out_valid, 0);

        disp(6'h01, 0, UNLOCKED, 5, 0, UNLOCKED, 7);
        cyc();
        idle();
        check("t1_valid", out_valid, 1);
        check("t1_x", out_x, 5);
        check("t1_y", out_y, 7);
        cyc();

        disp(6'h02, 3, ALU_MASTER, 0, 0, UNLOCKED, 1);
        cyc();
        idle();
        en[1] = 1; wa[1] = 3; wd[1] = 32'h22;
        cyc();
        idle();
        check("t2_wrong_bus", out_valid, 0);
        en[0] = 1; wa[0] = 3; wd[0] = 32'h11;
        cyc();
        idle();
        check("t2_valid", out_valid, 1);
        check("t2_x", out_x, 32'h11);
        cyc();

        disp(6'h03, 9, LOAD_STORE, 0, 0, UNLOCKED, 2);
        en[2] = 1; wa[2] = 9; wd[2] = 32'hAB;
        cyc();
        idle();
        check("t3_x", out_x, 32'hAB);
        cyc();

        for (int k = 0; k < 5; k++) begin
            disp(6'(10 + k), 0, UNLOCKED, 32'(k), 0, UNLOCKED, 32'(k));
            out_ready = 0;
            cyc();
        end
        idle();
        check("t4_full", full, 1);
        check("t4_first", out_op, 10);
        repeat (5) cyc();

        out_ready = 0;
        disp(6'h20, 4, ALU_SALVER, 0, 0, UNLOCKED, 0);
        cyc();
        disp(6'h21, 0, UNLOCKED, 1, 0, UNLOCKED, 1);
        cyc();
        idle();
        out_ready = 0;
        en[1] = 1; wa[1] = 4; wd[1] = 32'h44;
        cyc();
        idle();
        check("t5_older", out_op, 6'h20);
        cyc();
        check("t5_younger", out_op, 6'h21);
        cyc();

        out_ready = 0;
        disp(6'h30, 0, UNLOCKED, 1, 0, UNLOCKED, 1);
        cyc();
        disp(6'h31, 5, ALU_MASTER, 0, 0, UNLOCKED, 1);
        cyc();
        idle();
        flush = 1;
        disp(6'h32, 0, UNLOCKED, 1, 0, UNLOCKED, 1);
        cyc();
        idle();
        check("t6_full", full, 0);
        check("t6_valid", out_valid, 0);
        rdy = 0;
        disp(6'h33, 0, UNLOCKED, 1, 0, UNLOCKED, 1);
        cyc();
        idle();
        check("t6_frozen_insert", out_valid, 0);
        out_ready = 0;
        disp(6'h34, 0, UNLOCKED, 9, 0, UNLOCKED, 9);
        cyc();
        idle();
        rdy = 0;
        cyc();
        cyc();
        idle();
        check("t6_frozen_issue", out_valid, 1);
        cyc();

        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 499) == 0;
            rdy = $urandom_range(0, 7) != 0;
            flush = $urandom_range(0, 39) == 0;
            in_valid = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            in_op = 6'($urandom);
            in_rd = 5'($urandom);
            in_ax = 5'($urandom_range(0, 3));
            in_ay = 5'($urandom_range(0, 3));
            in_tx = 2'($urandom);
            in_ty = 2'($urandom);
            in_dx = $urandom;
            in_dy = $urandom;
            foreach (en[k]) begin
                en[k] = $urandom_range(0, 1) == 1;
                wa[k] = 5'($urandom_range(0, 3));
                wd[k] = $urandom;
            end
            cyc();
        end

        idle();
        repeat (10) cyc();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
